// File: rtl/gmii_frame_gen_if.sv
// GMII transmit bundle driven by the frame generator.
//
// Signals:
//   gmii_txd   - transmit data byte
//   gmii_tx_en - byte qualifier: gmii_txd carries frame data only while high
//   gmii_tx_er - transmit error (never asserted by this source)
//
// Handshake: gmii_tx_en acts as the valid; GMII has no ready, so the sink must
// accept a byte on every gtx_clk edge where gmii_tx_en is high. There is no
// backpressure and bytes inside a frame are strictly back-to-back.
interface gmii_frame_gen_if;
  logic [7:0] gmii_txd;
  logic       gmii_tx_en;
  logic       gmii_tx_er;

  modport master (output gmii_txd, output gmii_tx_en, output gmii_tx_er);
  modport slave  (input  gmii_txd, input  gmii_tx_en, input  gmii_tx_er);
endinterface

// File: rtl/gmii_frame_gen.sv
// Ethernet test-frame source for one GMII input of the output multiplexer.
// Emits bursts of frames: preamble, SFD, 14-byte header, incrementing payload,
// CRC-32 FCS, then an inter-frame gap of idle bytes.
//
// Ports:
//   gtx_clk, gtx_resetn      - 125 MHz clock, synchronous active-low reset
//   start, stop              - one-cycle burst control pulses
//   frame_len, ifg_len       - frame bytes (dst MAC..FCS) and IFG bytes, clamped
//   frame_count              - frames per burst, 0 = run until stop
//   dst_mac, src_mac,
//   ethertype                - header fields, most-significant byte sent first
//   gmii                     - GMII transmit bundle (registered outputs)
//   busy, done               - burst active / one-cycle end-of-burst pulse
//   frames_sent              - frames completed since reset (wraps)
//   dbg_state                - current FSM state for observation
module gmii_frame_gen #(
  parameter int C_MAX_FRAME_LEN = 9018,
  parameter int C_MIN_IFG       = 12
) (
  input  logic                    gtx_clk,
  input  logic                    gtx_resetn,
  input  logic                    start,
  input  logic                    stop,
  input  logic [15:0]             frame_len,
  input  logic [7:0]              ifg_len,
  input  logic [31:0]             frame_count,
  input  logic [47:0]             dst_mac,
  input  logic [47:0]             src_mac,
  input  logic [15:0]             ethertype,
  gmii_frame_gen_if.master        gmii,
  output logic                    busy,
  output logic                    done,
  output logic [31:0]             frames_sent,
  output logic [2:0]              dbg_state
);

  localparam logic [15:0] MAX_LEN = 16'(C_MAX_FRAME_LEN);
  localparam logic [7:0]  MIN_IFG = 8'(C_MIN_IFG);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_SFD,
    S_HEADER,
    S_PAYLOAD,
    S_FCS,
    S_IFG
  } state_t;

  // One byte of reflected CRC-32 (poly 0x04C11DB7 reflected = 0xEDB88320).
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction

  state_t       state_q, state_d;
  logic [15:0]  cnt_q, cnt_d;
  logic [15:0]  len_q, len_d;
  logic [7:0]   ifg_q, ifg_d;
  logic [31:0]  fc_q, fc_d;
  logic [31:0]  burst_cnt_q, burst_cnt_d;
  logic [111:0] hdr_q, hdr_d;
  logic [31:0]  crc_q, crc_d;
  logic         stop_pend_q, stop_pend_d;
  logic [7:0]   txd_q, txd_d;
  logic         tx_en_q, tx_en_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [31:0]  frames_sent_q, frames_sent_d;

  logic         latch_frame;
  logic [7:0]   data_byte;
  logic [31:0]  fcs;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q + 16'd1;
    len_d         = len_q;
    ifg_d         = ifg_q;
    fc_d          = fc_q;
    burst_cnt_d   = burst_cnt_q;
    hdr_d         = hdr_q;
    crc_d         = crc_q;
    stop_pend_d   = stop_pend_q | (stop & (state_q != S_IDLE));
    txd_d         = 8'h00;
    tx_en_d       = 1'b0;
    done_d        = 1'b0;
    frames_sent_d = frames_sent_q;
    latch_frame   = 1'b0;
    data_byte     = 8'h00;
    fcs           = ~crc_q;

    case (state_q)
      S_IDLE: begin
        cnt_d       = 16'd0;
        stop_pend_d = 1'b0;
        if (start) begin
          state_d     = S_PREAMBLE;
          fc_d        = frame_count;
          burst_cnt_d = 32'd0;
          latch_frame = 1'b1;
        end
      end
      S_PREAMBLE: begin
        txd_d   = 8'h55;
        tx_en_d = 1'b1;
        if (cnt_q == 16'd6) begin
          state_d = S_SFD;
          cnt_d   = 16'd0;
        end
      end
      S_SFD: begin
        txd_d   = 8'hD5;
        tx_en_d = 1'b1;
        crc_d   = 32'hFFFF_FFFF;
        state_d = S_HEADER;
        cnt_d   = 16'd0;
      end
      S_HEADER: begin
        // Header shifts out MSB-first, so the next byte is always the top one.
        data_byte = hdr_q[111:104];
        txd_d     = data_byte;
        tx_en_d   = 1'b1;
        hdr_d     = {hdr_q[103:0], 8'h00};
        crc_d     = crc_byte(crc_q, data_byte);
        if (cnt_q == 16'd13) begin
          state_d = S_PAYLOAD;
          cnt_d   = 16'd0;
        end
      end
      S_PAYLOAD: begin
        data_byte = cnt_q[7:0];
        txd_d     = data_byte;
        tx_en_d   = 1'b1;
        crc_d     = crc_byte(crc_q, data_byte);
        // Payload is frame length minus 14 header and 4 FCS bytes.
        if (cnt_q == len_q - 16'd19) begin
          state_d = S_FCS;
          cnt_d   = 16'd0;
        end
      end
      S_FCS: begin
        tx_en_d = 1'b1;
        case (cnt_q[1:0])
          2'd0:    txd_d = fcs[7:0];
          2'd1:    txd_d = fcs[15:8];
          2'd2:    txd_d = fcs[23:16];
          default: txd_d = fcs[31:24];
        endcase
        if (cnt_q == 16'd3) begin
          state_d       = S_IFG;
          cnt_d         = 16'd0;
          frames_sent_d = frames_sent_q + 32'd1;
          burst_cnt_d   = burst_cnt_q + 32'd1;
        end
      end
      S_IFG: begin
        if (cnt_q == {8'h00, ifg_q} - 16'd1) begin
          cnt_d = 16'd0;
          if (stop_pend_q || stop || (fc_q != 32'd0 && burst_cnt_q == fc_q)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d     = S_PREAMBLE;
            latch_frame = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Frame parameters are frozen at preamble entry so mid-frame config
    // writes only take effect on the next frame.
    if (latch_frame) begin
      if (frame_len < 16'd64)        len_d = 16'd64;
      else if (frame_len > MAX_LEN)  len_d = MAX_LEN;
      else                           len_d = frame_len;
      ifg_d = (ifg_len < MIN_IFG) ? MIN_IFG : ifg_len;
      hdr_d = {dst_mac, src_mac, ethertype};
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge gtx_clk) begin
    if (!gtx_resetn) begin
      state_q       <= S_IDLE;
      cnt_q         <= 16'd0;
      len_q         <= 16'd64;
      ifg_q         <= MIN_IFG;
      fc_q          <= 32'd0;
      burst_cnt_q   <= 32'd0;
      hdr_q         <= '0;
      crc_q         <= 32'hFFFF_FFFF;
      stop_pend_q   <= 1'b0;
      txd_q         <= 8'h00;
      tx_en_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      frames_sent_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      len_q         <= len_d;
      ifg_q         <= ifg_d;
      fc_q          <= fc_d;
      burst_cnt_q   <= burst_cnt_d;
      hdr_q         <= hdr_d;
      crc_q         <= crc_d;
      stop_pend_q   <= stop_pend_d;
      txd_q         <= txd_d;
      tx_en_q       <= tx_en_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      frames_sent_q <= frames_sent_d;
    end
  end

  assign gmii.gmii_txd   = txd_q;
  assign gmii.gmii_tx_en = tx_en_q;
  assign gmii.gmii_tx_er = 1'b0;
  assign busy            = busy_q;
  assign done            = done_q;
  assign frames_sent     = frames_sent_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_gmii_frame_gen.sv
// Testbench for gmii_frame_gen: table of burst configurations, randomized
// bursts checked against a byte-level frame model, and hand-written sequences
// for stop, mid-frame reset and mid-frame configuration changes.
module tb_gmii_frame_gen;

  logic        gtx_clk;
  logic        gtx_resetn;
  logic        start;
  logic        stop;
  logic [15:0] frame_len;
  logic [7:0]  ifg_len;
  logic [31:0] frame_count;
  logic [47:0] dst_mac;
  logic [47:0] src_mac;
  logic [15:0] ethertype;
  logic        busy;
  logic        done;
  logic [31:0] frames_sent;
  logic [2:0]  dbg_state;

  gmii_frame_gen_if g ();

  gmii_frame_gen dut (
    .gtx_clk     (gtx_clk),
    .gtx_resetn  (gtx_resetn),
    .start       (start),
    .stop        (stop),
    .frame_len   (frame_len),
    .ifg_len     (ifg_len),
    .frame_count (frame_count),
    .dst_mac     (dst_mac),
    .src_mac     (src_mac),
    .ethertype   (ethertype),
    .gmii        (g),
    .busy        (busy),
    .done        (done),
    .frames_sent (frames_sent),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset / bookkeeping ----------------
  initial begin
    gtx_clk = 1'b0;
    forever #4 gtx_clk = ~gtx_clk;
  end

  int n_err    = 0;
  int n_checks = 0;
  int cyc      = 0;
  int exp_sent = 0;

  always @(posedge gtx_clk) cyc <= cyc + 1;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] crc_tab [256];
  logic [7:0]  exp_q [$];

  function automatic void build_tab();
    logic [31:0] r;
    for (int n = 0; n < 256; n++) begin
      r = 32'(n);
      for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
      crc_tab[n] = r;
    end
  endfunction

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [7:0] idx;
    idx = c[7:0] ^ b;
    return crc_tab[idx] ^ (c >> 8);
  endfunction

  function automatic int clamp_len(input int l);
    if (l < 64)   return 64;
    if (l > 9018) return 9018;
    return l;
  endfunction

  function automatic int clamp_ifg(input int i);
    return (i < 12) ? 12 : i;
  endfunction

  // Appends one complete expected frame (preamble..FCS) to exp_q.
  function automatic void build_frame(input int leff);
    logic [7:0]  body [$];
    logic [31:0] c;
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 0; i < 6; i++) body.push_back(dst_mac[47 - 8*i -: 8]);
    for (int i = 0; i < 6; i++) body.push_back(src_mac[47 - 8*i -: 8]);
    body.push_back(ethertype[15:8]);
    body.push_back(ethertype[7:0]);
    for (int k = 0; k < leff - 18; k++) body.push_back(8'(k));
    c = 32'hFFFF_FFFF;
    foreach (body[i]) c = crc_upd(c, body[i]);
    c = ~c;
    foreach (body[i]) exp_q.push_back(body[i]);
    exp_q.push_back(c[7:0]);
    exp_q.push_back(c[15:8]);
    exp_q.push_back(c[23:16]);
    exp_q.push_back(c[31:24]);
  endfunction

  // ---------------- bus monitor ----------------
  logic [7:0] cap_q [$];
  int         fr_start [$];
  int         fr_len [$];
  logic       prev_en = 1'b0;
  logic       mon_en  = 1'b0;
  int         cur_len = 0;

  always @(negedge gtx_clk) begin
    if (mon_en) begin
      check("tx_er_low", g.gmii_tx_er, 0);
      if (g.gmii_tx_en === 1'b1) begin
        if (!prev_en) begin
          fr_start.push_back(cyc);
          cur_len = 0;
        end
        cap_q.push_back(g.gmii_txd);
        cur_len++;
      end else begin
        check("idle_txd_zero", g.gmii_txd, 0);
        if (prev_en) fr_len.push_back(cur_len);
      end
      prev_en = (g.gmii_tx_en === 1'b1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_mon();
    @(posedge gtx_clk);
    cap_q.delete();
    fr_start.delete();
    fr_len.delete();
    exp_q.delete();
  endtask

  task automatic pulse_start(output int s);
    @(negedge gtx_clk);
    start = 1'b1;
    @(negedge gtx_clk);
    start = 1'b0;
    s = cyc;
  endtask

  task automatic wait_done(input int budget, output int dcyc);
    int n;
    n = 0;
    dcyc = 0;
    while (n < budget) begin
      @(negedge gtx_clk);
      if (done === 1'b1) begin
        dcyc = cyc;
        break;
      end
      n++;
    end
    check("done_within_budget", (n < budget), 1);
  endtask

  task automatic wait_sop(input int nfr, input int budget);
    int n;
    n = 0;
    while (fr_start.size() < nfr && n < budget) begin
      @(negedge gtx_clk);
      n++;
    end
    check("sop_within_budget", (fr_start.size() >= nfr), 1);
  endtask

  // ---------------- scoreboard ----------------
  task automatic verify_frames(input int exp_n, input int l1, input int l2, input int ifg_e);
    int          off;
    int          leff;
    int          mism;
    logic [31:0] c;
    off = 0;
    check("frames_on_bus", fr_len.size(), exp_n);
    for (int i = 0; i < exp_n && i < fr_len.size(); i++) begin
      leff = (i == 0) ? l1 : l2;
      check("tx_en_cycles", fr_len[i], leff + 8);
      if (i > 0) check("frame_period", fr_start[i] - fr_start[i-1], ((i == 1) ? l1 : l2) + 8 + ifg_e);
      exp_q.delete();
      build_frame(leff);
      mism = -1;
      for (int j = 0; j < exp_q.size(); j++) begin
        if (off + j >= cap_q.size() || cap_q[off + j] !== exp_q[j]) begin
          mism = j;
          break;
        end
      end
      n_checks++;
      if (mism >= 0) begin
        n_err++;
        $display("FAIL frame_bytes: frame %0d byte %0d got 0x%0h expected 0x%0h", i, mism,
                 (off + mism < cap_q.size()) ? cap_q[off + mism] : 8'hxx, exp_q[mism]);
      end
      c = 32'hFFFF_FFFF;
      for (int j = off + 8; j < off + fr_len[i] && j < cap_q.size(); j++) c = crc_upd(c, cap_q[j]);
      check("fcs_residue", c, 32'hDEBB_20E3);
      off += fr_len[i];
    end
  endtask

  task automatic run_burst(input logic [15:0] len, input logic [7:0] ifg, input logic [31:0] fc,
                           input int exp_en, input int exp_period, input int exp_n);
    int s;
    int dcyc;
    clear_mon();
    frame_len   = len;
    ifg_len     = ifg;
    frame_count = fc;
    pulse_start(s);
    check("busy_after_start", busy, 1);
    wait_done(exp_n * exp_period + 100, dcyc);
    check("burst_cycles", dcyc - s, exp_n * exp_period);
    check("busy_low_at_done", busy, 0);
    if (fr_start.size() > 0) check("first_sop_latency", fr_start[0] - s, 1);
    verify_frames(exp_n, exp_en - 8, exp_en - 8, exp_period - exp_en);
    exp_sent += exp_n;
    check("frames_sent", frames_sent, exp_sent);
    @(negedge gtx_clk);
    check("done_one_cycle", done, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [15:0] len;
    logic [7:0]  ifg;
    logic [31:0] fc;
    int          exp_en;
    int          exp_period;
    int          exp_n;
  } vec_t;

  vec_t        vecs [5];
  logic [63:0] rnd64;
  int          r_len;
  int          r_ifg;
  int          r_fc;
  int          s0;
  int          d0;

  initial begin
    vecs[0] = '{16'd64,    8'd12,  32'd1, 72,   84,   1};
    vecs[1] = '{16'd10,    8'd3,   32'd3, 72,   84,   3};
    vecs[2] = '{16'hFFFF,  8'd20,  32'd1, 9026, 9046, 1};
    vecs[3] = '{16'd100,   8'd255, 32'd2, 108,  363,  2};
    vecs[4] = '{16'd64,    8'd0,   32'd2, 72,   84,   2};

    build_tab();
    gtx_resetn  = 1'b0;
    start       = 1'b0;
    stop        = 1'b0;
    frame_len   = 16'd64;
    ifg_len     = 8'd12;
    frame_count = 32'd1;
    dst_mac     = 48'h0102_0304_0506;
    src_mac     = 48'hA0B1_C2D3_E4F5;
    ethertype   = 16'h88B5;

    repeat (3) @(posedge gtx_clk);
    @(negedge gtx_clk);
    check("rst_txd", g.gmii_txd, 0);
    check("rst_tx_en", g.gmii_tx_en, 0);
    check("rst_tx_er", g.gmii_tx_er, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_frames_sent", frames_sent, 0);
    gtx_resetn = 1'b1;
    mon_en     = 1'b1;
    repeat (2) @(negedge gtx_clk);

    // stop alone while idle must not start anything
    stop = 1'b1;
    @(negedge gtx_clk);
    stop = 1'b0;
    repeat (3) @(negedge gtx_clk);
    check("stop_in_idle_busy", busy, 0);

    for (int i = 0; i < 5; i++) begin
      run_burst(vecs[i].len, vecs[i].ifg, vecs[i].fc, vecs[i].exp_en, vecs[i].exp_period, vecs[i].exp_n);
    end

    // randomized bursts checked against the model
    for (int i = 0; i < 5; i++) begin
      rnd64     = {$urandom(), $urandom()};
      dst_mac   = rnd64[47:0];
      rnd64     = {$urandom(), $urandom()};
      src_mac   = rnd64[47:0];
      ethertype = 16'($urandom_range(0, 65535));
      r_len     = $urandom_range(0, 300);
      r_ifg     = $urandom_range(0, 40);
      r_fc      = $urandom_range(1, 3);
      run_burst(16'(r_len), 8'(r_ifg), 32'(r_fc), clamp_len(r_len) + 8,
                clamp_len(r_len) + 8 + clamp_ifg(r_ifg), r_fc);
    end

    // start+stop together in idle: start wins, single frame burst completes
    clear_mon();
    frame_len   = 16'd64;
    ifg_len     = 8'd12;
    frame_count = 32'd1;
    @(negedge gtx_clk);
    start = 1'b1;
    stop  = 1'b1;
    @(negedge gtx_clk);
    start = 1'b0;
    stop  = 1'b0;
    s0 = cyc;
    check("start_stop_busy", busy, 1);
    wait_done(200, d0);
    check("start_stop_cycles", d0 - s0, 84);
    verify_frames(1, 64, 64, 12);
    exp_sent += 1;
    check("start_stop_frames_sent", frames_sent, exp_sent);

    // second start while busy is ignored; frame_len change applies to frame 2
    clear_mon();
    frame_count = 32'd2;
    pulse_start(s0);
    repeat (4) @(negedge gtx_clk);
    start = 1'b1;
    @(negedge gtx_clk);
    start = 1'b0;
    repeat (20) @(negedge gtx_clk);
    frame_len = 16'd128;
    wait_done(600, d0);
    check("midcfg_cycles", d0 - s0, 84 + 148);
    verify_frames(2, 64, 128, 12);
    exp_sent += 2;
    check("midcfg_frames_sent", frames_sent, exp_sent);

    // continuous mode ended by stop in the payload of frame 2
    clear_mon();
    frame_len   = 16'd1518;
    ifg_len     = 8'd12;
    frame_count = 32'd0;
    pulse_start(s0);
    wait_sop(2, 4000);
    repeat (200) @(negedge gtx_clk);
    stop = 1'b1;
    @(negedge gtx_clk);
    stop = 1'b0;
    wait_done(4000, d0);
    check("stop_cycles", d0 - s0, 2 * 1538);
    verify_frames(2, 1518, 1518, 12);
    exp_sent += 2;
    check("stop_frames_sent", frames_sent, exp_sent);

    // reset in the middle of the header
    clear_mon();
    frame_len   = 16'd64;
    frame_count = 32'd1;
    pulse_start(s0);
    wait_sop(1, 50);
    repeat (12) @(negedge gtx_clk);
    gtx_resetn = 1'b0;
    @(negedge gtx_clk);
    check("midrst_tx_en", g.gmii_tx_en, 0);
    check("midrst_txd", g.gmii_txd, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_frames_sent", frames_sent, 0);
    gtx_resetn = 1'b1;
    exp_sent   = 0;
    @(negedge gtx_clk);
    run_burst(16'd64, 8'd12, 32'd1, 72, 84, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/gmii_frame_gen.md
Name: gmii_frame_gen

Overview:
- Test-traffic source for the interconnect tester; drives one GMII input of the downstream GMII output multiplexer.
- Emits Ethernet frames with preamble, SFD, configurable header, incrementing-byte payload, CRC-32 FCS and inter-frame gap.
- Configured by static ports from the register block; produces a frame counter for status readback.

Parameters:
- C_MAX_FRAME_LEN, 9018, upper clamp for frame_len in bytes (header + payload + FCS).
- C_MIN_IFG, 12, lower clamp for ifg_len in byte times.

Ports:
- gtx_clk  in  1  GMII transmit clock, 125 MHz; sole clock.
- gtx_resetn  in  1  reset; synchronous, active-low.
- start  in  1  one-cycle pulse; begins a burst when idle.
- stop  in  1  one-cycle pulse; ends the burst after the current frame and its IFG.
- frame_len  in  16  frame bytes, dst MAC through FCS inclusive.
- ifg_len  in  8  idle bytes after each FCS.
- frame_count  in  32  frames per burst; 0 means continuous until stop.
- dst_mac  in  48  destination MAC; bits [47:40] are sent first.
- src_mac  in  48  source MAC; bits [47:40] are sent first.
- ethertype  in  16  EtherType/length field; bits [15:8] are sent first.
- gmii_txd  out  8  GMII data, registered.
- gmii_tx_en  out  1  GMII enable, registered.
- gmii_tx_er  out  1  GMII error; constant 0.
- busy  out  1  high from the cycle after an accepted start until return to IDLE.
- done  out  1  one-cycle pulse on the IDLE return.
- frames_sent  out  32  frames completed since reset; wraps at 2^32.

Behaviour:
- Reset (gtx_resetn=0 at a clock edge):
  - Next edge: gmii_txd=0x00, gmii_tx_en=0, gmii_tx_er=0, busy=0, done=0, frames_sent=0, state=IDLE.
  - Applies at any point mid-frame; the truncated frame is not counted.
- States: IDLE, PREAMBLE (7 bytes 0x55), SFD (1 byte 0xD5), HEADER (dst_mac, src_mac, ethertype; 14 bytes), PAYLOAD, FCS (4 bytes), IFG.
- Start:
  - start sampled high in IDLE at edge N: first 0x55 with gmii_tx_en=1 appears after edge N+1.
  - start outside IDLE is ignored.
- Per-burst latch: frame_count is latched at start.
- Per-frame latch, at entry to PREAMBLE:
  - frame_len is clamped to [64, C_MAX_FRAME_LEN]; ifg_len is clamped to [C_MIN_IFG, 255].
  - dst_mac, src_mac and ethertype are latched.
- PAYLOAD: L_eff-18 bytes; payload byte k = k[7:0], restarting at 0x00 each frame.
- FCS:
  - CRC-32, polynomial 0x04C11DB7, reflected, init 0xFFFFFFFF, final complement.
  - Covers HEADER+PAYLOAD only; transmitted least-significant byte first.
  - CRC is computed byte-parallel with no extra cycles.
- IFG: gmii_tx_en=0, gmii_txd=0x00 for the latched IFG byte count.
- frames_sent increments in the cycle the last FCS byte is driven.
- Frame timing: 8+L_eff bytes with tx_en high, then IFG bytes low; no gaps inside a frame.
- After IFG:
  - Goes to IDLE if stop is pending or the frames done equal a nonzero frame_count; otherwise goes to PREAMBLE.
  - IDLE return: busy deasserts and done pulses on the same edge.
- stop:
  - A stop pulse while busy sets a sticky pending flag; the flag clears on IDLE.
  - stop in IDLE is ignored.
  - start and stop together in IDLE: start is accepted, stop is ignored.
- Config changes mid-frame do not affect the frame in flight.

Test Plan:
- Reset, then start with frame_len=64, ifg_len=12, frame_count=1:
  - tx_en high exactly 72 cycles: 7×0x55, 0xD5, header, payload 0x00..0x2D, 4 FCS bytes.
  - Then 12 idle cycles; done pulses; frames_sent=1.
- FCS check: a reference model's CRC over header+payload matches the 4 FCS bytes; the running reflected CRC over header+payload+FCS equals residue 0xDEBB20E3.
- Clamping: frame_len=10, ifg_len=3, frame_count=3:
  - Three 64-byte frames with 12-byte IFGs; frame period 84 cycles.
  - frames_sent=3, busy low after 252 cycles.
- Continuous mode: frame_count=0, frame_len=1518; pulse stop mid-payload of frame 2.
  - Frame 2 completes with valid FCS, then its 12-byte IFG, then IDLE; frames_sent=2.
- Reset mid-frame: assert gtx_resetn=0 during HEADER.
  - Next edge tx_en=0, frames_sent=0, busy=0; new start yields a clean frame.
- Start while busy plus mid-frame config change:
  - Second start ignored; frame_len changed from 64 to 128 during frame 1.
  - Frame 1 is 64 bytes, frame 2 is 128 bytes.
